// File: rtl/centroid_pkg.sv
// Shared types and default widths for the centroid engine.
//   state_e  : result-sequencer FSM states
//   result_t : one per-channel result as presented on the output port
//   *_DEF    : default parameter values used by the top and the divider
package centroid_pkg;

  localparam int unsigned H_WIDTH_DEF   = 11;
  localparam int unsigned V_WIDTH_DEF   = 10;
  localparam int unsigned ACC_WIDTH_DEF = 32;
  localparam int unsigned NUM_CH_DEF    = 2;
  localparam int unsigned CH_WIDTH_DEF  = (NUM_CH_DEF > 1) ? $clog2(NUM_CH_DEF) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DIVIDE = 2'd2,
    EMIT   = 2'd3
  } state_e;

  // Field widths track the default parameters of centroid_engine.
  typedef struct packed {
    logic [H_WIDTH_DEF-1:0]   x;
    logic [V_WIDTH_DEF-1:0]   y;
    logic [ACC_WIDTH_DEF-1:0] count;
    logic [CH_WIDTH_DEF-1:0]  ch;
    logic                     empty;
  } result_t;

endpackage

// File: rtl/centroid_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// The first quotient bit is resolved on the start edge, so done_out pulses
// for one cycle exactly WIDTH cycles after start_in was presented.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   start_in       : latch operands and begin (divisor must be non-zero)
//   dividend_in    : dividend
//   divisor_in     : divisor
//   quotient_out   : low Q_WIDTH bits of the quotient, held after done
//   done_out       : one-cycle completion pulse
module centroid_divider
  import centroid_pkg::*;
#(
  parameter int unsigned WIDTH   = ACC_WIDTH_DEF,
  parameter int unsigned Q_WIDTH = WIDTH
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic [WIDTH-1:0]   dividend_in,
  input  logic [WIDTH-1:0]   divisor_in,
  output logic [Q_WIDTH-1:0] quotient_out,
  output logic               done_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] src_rem_c, src_quo_c, src_div_c;
  logic [WIDTH:0]   shift_c, diff_c;

  // One restoring step; on start the step operates directly on the operands.
  always_comb begin
    src_rem_c = start_in ? '0 : rem_q;
    src_quo_c = start_in ? dividend_in : quo_q;
    src_div_c = start_in ? divisor_in : div_q;
    shift_c   = {src_rem_c, src_quo_c[WIDTH-1]};
    diff_c    = shift_c - {1'b0, src_div_c};

    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;

    if (start_in || run_q) begin
      rem_d = diff_c[WIDTH] ? shift_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
      quo_d = {src_quo_c[WIDTH-2:0], ~diff_c[WIDTH]};
      div_d = src_div_c;
      if (start_in) begin
        cnt_d = CNT_W'(WIDTH - 1);
        run_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          run_d  = 1'b0;
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient_out = quo_q[Q_WIDTH-1:0];
  assign done_out     = done_q;

endmodule

// File: rtl/centroid_engine.sv
// Multi-channel centroid engine. Accumulates sum-x, sum-y and pixel count per
// channel over a frame; on tabulate_in the sums are snapshotted and divided in
// the background while the next frame accumulates, then one result per channel
// is emitted in channel order.
//   clk_in, rst_in        : pixel clock, asynchronous active-high reset
//   x_in, y_in, ch_in     : pixel coordinate and channel
//   valid_in              : accumulate this pixel
//   tabulate_in           : frame-end strobe
//   x_out, y_out          : centroid of ch_out (0 when empty_out)
//   count_out, ch_out     : pixel count and channel of the result
//   empty_out, valid_out  : channel had no pixels / one-cycle result strobe
//   busy_out, overrun_out : results pending / tabulate rejected while busy
// Optional macro CENTROID_BBOX_EN adds per-channel bounding box outputs
// bbox_{x,y}_{min,max}_out, valid alongside valid_out.
module centroid_engine
  import centroid_pkg::*;
#(
  parameter  int unsigned H_WIDTH   = H_WIDTH_DEF,
  parameter  int unsigned V_WIDTH   = V_WIDTH_DEF,
  parameter  int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
  parameter  int unsigned NUM_CH    = NUM_CH_DEF,
  localparam int unsigned CH_WIDTH  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [H_WIDTH-1:0]   x_in,
  input  logic [V_WIDTH-1:0]   y_in,
  input  logic [CH_WIDTH-1:0]  ch_in,
  input  logic                 valid_in,
  input  logic                 tabulate_in,
  output logic [H_WIDTH-1:0]   x_out,
  output logic [V_WIDTH-1:0]   y_out,
  output logic [ACC_WIDTH-1:0] count_out,
  output logic [CH_WIDTH-1:0]  ch_out,
  output logic                 empty_out,
  output logic                 valid_out,
  output logic                 busy_out,
  output logic                 overrun_out
`ifdef CENTROID_BBOX_EN
  ,
  output logic [H_WIDTH-1:0]   bbox_x_min_out,
  output logic [H_WIDTH-1:0]   bbox_x_max_out,
  output logic [V_WIDTH-1:0]   bbox_y_min_out,
  output logic [V_WIDTH-1:0]   bbox_y_max_out
`endif
);

  state_e               state_q, state_d;
  logic [CH_WIDTH-1:0]  ch_q, ch_d;
  result_t              res_q, res_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  logic [ACC_WIDTH-1:0] sum_x_q [NUM_CH];
  logic [ACC_WIDTH-1:0] sum_x_d [NUM_CH];
  logic [ACC_WIDTH-1:0] sum_y_q [NUM_CH];
  logic [ACC_WIDTH-1:0] sum_y_d [NUM_CH];
  logic [ACC_WIDTH-1:0] cnt_q   [NUM_CH];
  logic [ACC_WIDTH-1:0] cnt_d   [NUM_CH];
  logic [ACC_WIDTH-1:0] snap_sx_q  [NUM_CH];
  logic [ACC_WIDTH-1:0] snap_sx_d  [NUM_CH];
  logic [ACC_WIDTH-1:0] snap_sy_q  [NUM_CH];
  logic [ACC_WIDTH-1:0] snap_sy_d  [NUM_CH];
  logic [ACC_WIDTH-1:0] snap_cnt_q [NUM_CH];
  logic [ACC_WIDTH-1:0] snap_cnt_d [NUM_CH];

  logic                 hit_c     [NUM_CH];
  logic [ACC_WIDTH-1:0] add_sx_c  [NUM_CH];
  logic [ACC_WIDTH-1:0] add_sy_c  [NUM_CH];
  logic [ACC_WIDTH-1:0] add_cnt_c [NUM_CH];

  logic                 tab_accept_c;
  logic                 start_c;
  logic                 cur_empty_c;
  logic [H_WIDTH-1:0]   quo_x_c;
  logic [V_WIDTH-1:0]   quo_y_c;
  logic                 done_x_c, done_y_c;

  assign tab_accept_c = tabulate_in && (state_q == IDLE);

  // Live accumulators; a pixel arriving with an accepted tabulate joins the closing frame.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      hit_c[c]      = valid_in && (ch_in == CH_WIDTH'(c));
      add_sx_c[c]   = sum_x_q[c] + (hit_c[c] ? ACC_WIDTH'(x_in) : '0);
      add_sy_c[c]   = sum_y_q[c] + (hit_c[c] ? ACC_WIDTH'(y_in) : '0);
      add_cnt_c[c]  = cnt_q[c] + (hit_c[c] ? ACC_WIDTH'(1) : '0);
      sum_x_d[c]    = tab_accept_c ? '0 : add_sx_c[c];
      sum_y_d[c]    = tab_accept_c ? '0 : add_sy_c[c];
      cnt_d[c]      = tab_accept_c ? '0 : add_cnt_c[c];
      snap_sx_d[c]  = tab_accept_c ? add_sx_c[c]  : snap_sx_q[c];
      snap_sy_d[c]  = tab_accept_c ? add_sy_c[c]  : snap_sy_q[c];
      snap_cnt_d[c] = tab_accept_c ? add_cnt_c[c] : snap_cnt_q[c];
    end
  end

  // Result sequencer: walk channels, dividing the non-empty ones.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    res_d       = res_q;
    valid_d     = 1'b0;
    overrun_d   = tabulate_in && (state_q != IDLE);
    start_c     = 1'b0;
    cur_empty_c = (snap_cnt_q[ch_q] == '0);

    case (state_q)
      IDLE: begin
        if (tab_accept_c) begin
          state_d = LOAD;
          ch_d    = '0;
        end
      end
      LOAD: begin
        if (cur_empty_c) begin
          state_d = EMIT;
        end else begin
          start_c = 1'b1;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        if (done_x_c && done_y_c) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        valid_d     = 1'b1;
        res_d.x     = cur_empty_c ? '0 : H_WIDTH_DEF'(quo_x_c);
        res_d.y     = cur_empty_c ? '0 : V_WIDTH_DEF'(quo_y_c);
        res_d.count = ACC_WIDTH_DEF'(snap_cnt_q[ch_q]);
        res_d.ch    = CH_WIDTH_DEF'(ch_q);
        res_d.empty = cur_empty_c;
        if (ch_q == CH_WIDTH'(NUM_CH - 1)) begin
          state_d = IDLE;
          ch_d    = '0;
        end else begin
          state_d = LOAD;
          ch_d    = ch_q + CH_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      res_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum_x_q[c]    <= '0;
        sum_y_q[c]    <= '0;
        cnt_q[c]      <= '0;
        snap_sx_q[c]  <= '0;
        snap_sy_q[c]  <= '0;
        snap_cnt_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      res_q     <= res_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      for (int c = 0; c < NUM_CH; c++) begin
        sum_x_q[c]    <= sum_x_d[c];
        sum_y_q[c]    <= sum_y_d[c];
        cnt_q[c]      <= cnt_d[c];
        snap_sx_q[c]  <= snap_sx_d[c];
        snap_sy_q[c]  <= snap_sy_d[c];
        snap_cnt_q[c] <= snap_cnt_d[c];
      end
    end
  end

  centroid_divider #(.WIDTH(ACC_WIDTH), .Q_WIDTH(H_WIDTH)) u_div_x (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (start_c),
    .dividend_in  (snap_sx_q[ch_q]),
    .divisor_in   (snap_cnt_q[ch_q]),
    .quotient_out (quo_x_c),
    .done_out     (done_x_c)
  );

  centroid_divider #(.WIDTH(ACC_WIDTH), .Q_WIDTH(V_WIDTH)) u_div_y (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (start_c),
    .dividend_in  (snap_sy_q[ch_q]),
    .divisor_in   (snap_cnt_q[ch_q]),
    .quotient_out (quo_y_c),
    .done_out     (done_y_c)
  );

  assign x_out       = H_WIDTH'(res_q.x);
  assign y_out       = V_WIDTH'(res_q.y);
  assign count_out   = ACC_WIDTH'(res_q.count);
  assign ch_out      = CH_WIDTH'(res_q.ch);
  assign empty_out   = res_q.empty;
  assign valid_out   = valid_q;
  assign busy_out    = (state_q != IDLE);
  assign overrun_out = overrun_q;

`ifdef CENTROID_BBOX_EN
  logic [H_WIDTH-1:0] xmin_q [NUM_CH];
  logic [H_WIDTH-1:0] xmin_d [NUM_CH];
  logic [H_WIDTH-1:0] xmax_q [NUM_CH];
  logic [H_WIDTH-1:0] xmax_d [NUM_CH];
  logic [V_WIDTH-1:0] ymin_q [NUM_CH];
  logic [V_WIDTH-1:0] ymin_d [NUM_CH];
  logic [V_WIDTH-1:0] ymax_q [NUM_CH];
  logic [V_WIDTH-1:0] ymax_d [NUM_CH];
  logic [H_WIDTH-1:0] snap_xmin_q [NUM_CH];
  logic [H_WIDTH-1:0] snap_xmin_d [NUM_CH];
  logic [H_WIDTH-1:0] snap_xmax_q [NUM_CH];
  logic [H_WIDTH-1:0] snap_xmax_d [NUM_CH];
  logic [V_WIDTH-1:0] snap_ymin_q [NUM_CH];
  logic [V_WIDTH-1:0] snap_ymin_d [NUM_CH];
  logic [V_WIDTH-1:0] snap_ymax_q [NUM_CH];
  logic [V_WIDTH-1:0] snap_ymax_d [NUM_CH];
  logic [H_WIDTH-1:0] nx_min_c [NUM_CH];
  logic [H_WIDTH-1:0] nx_max_c [NUM_CH];
  logic [V_WIDTH-1:0] ny_min_c [NUM_CH];
  logic [V_WIDTH-1:0] ny_max_c [NUM_CH];
  logic [H_WIDTH-1:0] bb_xmin_q, bb_xmin_d, bb_xmax_q, bb_xmax_d;
  logic [V_WIDTH-1:0] bb_ymin_q, bb_ymin_d, bb_ymax_q, bb_ymax_d;

  // Bounding box trackers follow the same snapshot/clear rule as the sums.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      nx_min_c[c]    = (hit_c[c] && (x_in < xmin_q[c])) ? x_in : xmin_q[c];
      nx_max_c[c]    = (hit_c[c] && (x_in > xmax_q[c])) ? x_in : xmax_q[c];
      ny_min_c[c]    = (hit_c[c] && (y_in < ymin_q[c])) ? y_in : ymin_q[c];
      ny_max_c[c]    = (hit_c[c] && (y_in > ymax_q[c])) ? y_in : ymax_q[c];
      xmin_d[c]      = tab_accept_c ? '1 : nx_min_c[c];
      xmax_d[c]      = tab_accept_c ? '0 : nx_max_c[c];
      ymin_d[c]      = tab_accept_c ? '1 : ny_min_c[c];
      ymax_d[c]      = tab_accept_c ? '0 : ny_max_c[c];
      snap_xmin_d[c] = tab_accept_c ? nx_min_c[c] : snap_xmin_q[c];
      snap_xmax_d[c] = tab_accept_c ? nx_max_c[c] : snap_xmax_q[c];
      snap_ymin_d[c] = tab_accept_c ? ny_min_c[c] : snap_ymin_q[c];
      snap_ymax_d[c] = tab_accept_c ? ny_max_c[c] : snap_ymax_q[c];
    end
    bb_xmin_d = bb_xmin_q;
    bb_xmax_d = bb_xmax_q;
    bb_ymin_d = bb_ymin_q;
    bb_ymax_d = bb_ymax_q;
    if (state_q == EMIT) begin
      bb_xmin_d = cur_empty_c ? '0 : snap_xmin_q[ch_q];
      bb_xmax_d = cur_empty_c ? '0 : snap_xmax_q[ch_q];
      bb_ymin_d = cur_empty_c ? '0 : snap_ymin_q[ch_q];
      bb_ymax_d = cur_empty_c ? '0 : snap_ymax_q[ch_q];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bb_xmin_q <= '0;
      bb_xmax_q <= '0;
      bb_ymin_q <= '0;
      bb_ymax_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        xmin_q[c]      <= '1;
        xmax_q[c]      <= '0;
        ymin_q[c]      <= '1;
        ymax_q[c]      <= '0;
        snap_xmin_q[c] <= '0;
        snap_xmax_q[c] <= '0;
        snap_ymin_q[c] <= '0;
        snap_ymax_q[c] <= '0;
      end
    end else begin
      bb_xmin_q <= bb_xmin_d;
      bb_xmax_q <= bb_xmax_d;
      bb_ymin_q <= bb_ymin_d;
      bb_ymax_q <= bb_ymax_d;
      for (int c = 0; c < NUM_CH; c++) begin
        xmin_q[c]      <= xmin_d[c];
        xmax_q[c]      <= xmax_d[c];
        ymin_q[c]      <= ymin_d[c];
        ymax_q[c]      <= ymax_d[c];
        snap_xmin_q[c] <= snap_xmin_d[c];
        snap_xmax_q[c] <= snap_xmax_d[c];
        snap_ymin_q[c] <= snap_ymin_d[c];
        snap_ymax_q[c] <= snap_ymax_d[c];
      end
    end
  end

  assign bbox_x_min_out = bb_xmin_q;
  assign bbox_x_max_out = bb_xmax_q;
  assign bbox_y_min_out = bb_ymin_q;
  assign bbox_y_max_out = bb_ymax_q;
`endif

endmodule
